// File: rtl/ram_port_arbiter.sv
// Shares one RAM port between the Apple core and a host/loader. The core always wins (a combinational bypass). Host accesses take 4 cycles: IDLE, SETUP, ACCESS, DONE.
// A core slot during SETUP or ACCESS aborts the host access, which is then retried from IDLE.
module ram_port_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             CLK_14M,
  input  logic             reset,
  input  logic             cpu_slot,
  input  logic [17:0]      core_addr,
  input  logic             core_we,
  input  logic [7:0]       core_di,
  input  logic             core_aux,
  input  logic             host_req,
  input  logic             host_we,
  input  logic [17:0]      host_addr,
  input  logic             host_aux,
  input  logic [7:0]       host_di,
  output logic             host_ack,
  output logic [7:0]       host_do,
  output logic             host_busy,
  output logic [17:0]      ram_addr,
  output logic             ram_we,
  output logic [7:0]       ram_di,
  output logic             ram_aux,
  input  logic [15:0]      ram_do,
  output logic [CNT_W-1:0] abort_cnt
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t      state, state_nxt;
  logic        lat_we, lat_aux;
  logic [17:0] lat_addr;
  logic [7:0]  lat_di;
  logic        start, abort, rd_done;

  always_ff @(posedge CLK_14M) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    abort     = 1'b0;
    rd_done   = 1'b0;
    host_ack  = 1'b0;
    host_busy = (state != IDLE);
    ram_addr  = core_addr;
    ram_di    = core_di;
    ram_aux   = core_aux;
    ram_we    = 1'b0;
    case (state)
      IDLE: begin
        if (host_req && !cpu_slot) begin
          start     = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        ram_addr = lat_addr;
        ram_di   = lat_di;
        ram_aux  = lat_aux;
        if (cpu_slot) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        ram_addr = lat_addr;
        ram_di   = lat_di;
        ram_aux  = lat_aux;
        // A reset landing mid-access must never commit the host write.
        ram_we   = lat_we & ~reset;
        if (cpu_slot) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else begin
          rd_done   = ~lat_we;
          state_nxt = DONE;
        end
      end
      DONE: begin
        host_ack  = 1'b1;
        state_nxt = IDLE;
      end
    endcase
    if (cpu_slot) begin
      ram_addr = core_addr;
      ram_di   = core_di;
      ram_aux  = core_aux;
      ram_we   = core_we;
    end
  end

  always_ff @(posedge CLK_14M) begin
    if (reset) begin
      lat_we    <= 1'b0;
      lat_aux   <= 1'b0;
      lat_addr  <= '0;
      lat_di    <= '0;
      host_do   <= '0;
      abort_cnt <= '0;
    end else begin
      if (start) begin
        lat_we   <= host_we;
        lat_aux  <= host_aux;
        lat_addr <= host_addr;
        lat_di   <= host_di;
      end
      if (rd_done) host_do <= lat_aux ? ram_do[15:8] : ram_do[7:0];
      if (abort && (abort_cnt != '1)) abort_cnt <= abort_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed cases, then random host traffic under random core slots.
// It checks the DUT against a byte-level RAM reference model and a scoreboard of expected read data.
module tb_ram_port_arbiter;

  logic        CLK_14M = 1'b0;
  logic        reset, cpu_slot;
  logic [17:0] core_addr;
  logic        core_we, core_aux;
  logic [7:0]  core_di;
  logic        host_req, host_we, host_aux;
  logic [17:0] host_addr;
  logic [7:0]  host_di;
  logic        host_ack, host_busy, ram_we, ram_aux;
  logic [7:0]  host_do, ram_di;
  logic [17:0] ram_addr;
  logic [15:0] ram_do;
  logic [7:0]  abort_cnt;
  logic        s_ack, s_busy, s_we, s_aux;
  logic [7:0]  s_do, s_di;
  logic [17:0] s_addr;
  logic [1:0]  s_cnt;

  always #35 CLK_14M = ~CLK_14M;

  ram_port_arbiter #(.CNT_W(8)) dut (
    .CLK_14M(CLK_14M), .reset(reset), .cpu_slot(cpu_slot),
    .core_addr(core_addr), .core_we(core_we), .core_di(core_di), .core_aux(core_aux),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_aux(host_aux), .host_di(host_di),
    .host_ack(host_ack), .host_do(host_do), .host_busy(host_busy),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_di(ram_di), .ram_aux(ram_aux), .ram_do(ram_do),
    .abort_cnt(abort_cnt));

  ram_port_arbiter #(.CNT_W(2)) dut_sat (
    .CLK_14M(CLK_14M), .reset(reset), .cpu_slot(cpu_slot),
    .core_addr(core_addr), .core_we(core_we), .core_di(core_di), .core_aux(core_aux),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_aux(host_aux), .host_di(host_di),
    .host_ack(s_ack), .host_do(s_do), .host_busy(s_busy),
    .ram_addr(s_addr), .ram_we(s_we), .ram_di(s_di), .ram_aux(s_aux), .ram_do(ram_do),
    .abort_cnt(s_cnt));

  // The RAM is indexed by the low address byte.
  logic [7:0] main_mem [256];
  logic [7:0] aux_mem  [256];
  logic [7:0] ref_main [256];
  logic [7:0] ref_aux  [256];
  assign ram_do = {aux_mem[ram_addr[7:0]], main_mem[ram_addr[7:0]]};

  int n_chk = 0, n_pass = 0;
  int host_wr_cycles = 0;
  logic        last_wr_aux;
  logic [7:0]  last_wr_di;
  logic [17:0] last_wr_addr;
  logic [7:0]  exp_q[$];
  logic [7:0]  last_rd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  always @(posedge CLK_14M) begin
    if (ram_we) begin
      if (ram_aux) aux_mem[ram_addr[7:0]] = ram_di;
      else         main_mem[ram_addr[7:0]] = ram_di;
    end
    if (cpu_slot && core_we) begin
      if (core_aux) ref_aux[core_addr[7:0]] = core_di;
      else          ref_main[core_addr[7:0]] = core_di;
    end
  end

  always @(negedge CLK_14M) begin
    if (ram_we && !cpu_slot) begin
      host_wr_cycles++;
      last_wr_aux  = ram_aux;
      last_wr_di   = ram_di;
      last_wr_addr = ram_addr;
    end
    if (cpu_slot)
      chk("core_mux", {4'd0, ram_we, ram_aux, ram_di, ram_addr}, {4'd0, core_we, core_aux, core_di, core_addr});
    if (host_ack) begin
      if (exp_q.size() == 0) chk("ack_unexpected", {31'd0, host_ack}, 32'd0);
      else                   chk("host_do", {24'd0, host_do}, {24'd0, exp_q.pop_front()});
    end
  end

  // Called just after a rising edge; mask bit c is cpu_slot during cycle c+1.
  task automatic run_txn(input logic we, input logic [17:0] addr, input logic aux, input logic [7:0] di,
                         input logic [31:0] mask, input int rst_at, input bit core_first,
                         output int cycles, output int wr_seen);
    int  base;
    bit  acked = 0;
    logic [7:0] a;
    a = addr[7:0];
    host_req = 1'b1; host_we = we; host_addr = addr; host_aux = aux; host_di = di;
    if (we) exp_q.push_back(last_rd);
    else begin
      last_rd = aux ? ref_aux[a] : ref_main[a];
      exp_q.push_back(last_rd);
    end
    base = host_wr_cycles;
    cycles = 0;
    for (int c = 0; c < 60; c++) begin
      cpu_slot  = (c < 32) ? mask[c] : 1'b0;
      core_addr = 18'($urandom);
      core_di   = 8'($urandom);
      core_aux  = 1'($urandom);
      core_we   = 1'b0;
      if (core_first && c == 0) begin
        core_we = 1'b1; core_addr = 18'h01000; core_di = 8'h77; core_aux = 1'b0;
      end
      if (rst_at == c + 1) reset = 1'b1;
      @(negedge CLK_14M);
      cycles = c + 1;
      if (core_first && c == 0) begin
        chk("core_pri_we", {31'd0, ram_we}, 32'd1);
        chk("core_pri_addr", {14'd0, ram_addr}, 32'h01000);
        chk("core_pri_busy", {31'd0, host_busy}, 32'd0);
      end
      if (reset) begin
        chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
        chk("rst_no_ack", {31'd0, host_ack}, 32'd0);
        break;
      end
      if (host_ack) begin acked = 1; break; end
      @(posedge CLK_14M); #1;
    end
    @(posedge CLK_14M); #1;
    cpu_slot = 1'b0;
    core_we  = 1'b0;
    wr_seen  = host_wr_cycles - base;
    if (rst_at != 0) begin
      reset = 1'b0; host_req = 1'b0;
      void'(exp_q.pop_back());
      last_rd = 8'h00;
    end else begin
      chk("ack_timeout", {31'd0, acked}, 32'd1);
      if (acked && we) begin
        if (aux) ref_aux[a] = di;
        else     ref_main[a] = di;
      end
    end
  endtask

  int cyc, wr, bad;
  logic        r_we, r_aux;
  logic [7:0]  r_di;
  logic [17:0] r_addr;

  initial begin
    reset = 1'b1; cpu_slot = 1'b0; core_addr = '0; core_we = 1'b0; core_di = '0; core_aux = 1'b0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_aux = 1'b0; host_di = '0;
    last_rd = 8'h00;
    for (int i = 0; i < 256; i++) begin
      main_mem[i] = 8'($urandom); aux_mem[i] = 8'($urandom);
    end
    main_mem[8'hF4] = 8'h5A; aux_mem[8'hF4] = 8'hA5;
    for (int i = 0; i < 256; i++) begin
      ref_main[i] = main_mem[i]; ref_aux[i] = aux_mem[i];
    end
    repeat (3) @(posedge CLK_14M);
    @(negedge CLK_14M);
    chk("rst_ack", {31'd0, host_ack}, 32'd0);
    chk("rst_do", {24'd0, host_do}, 32'd0);
    chk("rst_cnt", {24'd0, abort_cnt}, 32'd0);
    chk("rst_busy", {31'd0, host_busy}, 32'd0);
    chk("rst_we", {31'd0, ram_we}, 32'd0);
    @(posedge CLK_14M); #1;
    reset = 1'b0;

    // Plain read of the A55A word, main byte.
    run_txn(1'b0, 18'h003F4, 1'b0, 8'h00, 32'h0, 0, 0, cyc, wr);
    chk("rd_latency", cyc, 4);
    chk("rd_no_write", wr, 0);

    // Aux write, issued back-to-back with the read.
    run_txn(1'b1, 18'h00400, 1'b1, 8'hC3, 32'h0, 0, 0, cyc, wr);
    chk("wr_latency", cyc, 4);
    chk("wr_count", wr, 1);
    chk("wr_aux", {31'd0, last_wr_aux}, 32'd1);
    chk("wr_di", {24'd0, last_wr_di}, 32'hC3);
    chk("wr_addr", {14'd0, last_wr_addr}, 32'h00400);

    // Abort in ACCESS, then an automatic retry.
    run_txn(1'b1, 18'h00021, 1'b0, 8'h3C, 32'h4, 0, 0, cyc, wr);
    chk("abort_acc_latency", cyc, 7);
    chk("abort_acc_writes", wr, 1);
    chk("abort_acc_cnt", {24'd0, abort_cnt}, 32'd1);

    // Four SETUP aborts: five in total, so the 2-bit counter saturates.
    run_txn(1'b0, 18'h00021, 1'b0, 8'h00, 32'hAA, 0, 0, cyc, wr);
    chk("multi_abort_latency", cyc, 12);
    chk("cnt_after5", {24'd0, abort_cnt}, 32'd5);
    chk("sat_after5", {30'd0, s_cnt}, 32'd3);
    run_txn(1'b1, 18'h00022, 1'b0, 8'h11, 32'h2, 0, 0, cyc, wr);
    chk("setup_abort_latency", cyc, 6);
    chk("cnt_after6", {24'd0, abort_cnt}, 32'd6);
    chk("sat_after6", {30'd0, s_cnt}, 32'd3);

    // A core write in IDLE while host_req is high: no start and no abort count.
    run_txn(1'b0, 18'h00022, 1'b0, 8'h00, 32'h1, 0, 1, cyc, wr);
    chk("core_pri_latency", cyc, 5);
    chk("core_pri_cnt", {24'd0, abort_cnt}, 32'd6);
    chk("core_pri_hostwr", wr, 0);
    run_txn(1'b0, 18'h00000, 1'b0, 8'h00, 32'h0, 0, 0, cyc, wr);

    // Reset during the ACCESS cycle of a write.
    run_txn(1'b1, 18'h00030, 1'b0, 8'h99, 32'h0, 3, 0, cyc, wr);
    chk("rst_mid_writes", wr, 0);
    chk("rst_mid_busy", {31'd0, host_busy}, 32'd0);
    chk("rst_mid_do", {24'd0, host_do}, 32'd0);
    chk("rst_mid_cnt", {24'd0, abort_cnt}, 32'd0);
    chk("rst_mid_sat", {30'd0, s_cnt}, 32'd0);
    run_txn(1'b0, 18'h00030, 1'b0, 8'h00, 32'h0, 0, 0, cyc, wr);

    for (int t = 0; t < 80; t++) begin
      r_we = 1'($urandom); r_aux = 1'($urandom); r_di = 8'($urandom); r_addr = 18'($urandom);
      if ($urandom_range(1, 0) == 1) begin
        host_req = 1'b0;
        @(posedge CLK_14M); #1;
      end
      run_txn(r_we, r_addr, r_aux, r_di, $urandom & $urandom & $urandom, 0, 0, cyc, wr);
      chk("rand_writes", wr, {31'd0, r_we});
    end
    host_req = 1'b0;
    repeat (3) @(posedge CLK_14M);
    #1;

    bad = 0;
    for (int i = 0; i < 256; i++)
      if (main_mem[i] !== ref_main[i] || aux_mem[i] !== ref_aux[i]) bad++;
    chk("mem_contents", bad, 0);
    chk("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter: CNT_W, 8, width of the abort counter.
REQ-002 SHALL have port: CLK_14M  in  1  14.31818 MHz master clock; the only clock.
REQ-003 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port: cpu_slot  in  1  high while the Apple core owns the RAM port this cycle.
REQ-005 SHALL have ports: core_addr in 18, core_we in 1, core_di in 8, core_aux in 1; the core-side RAM request.
REQ-006 SHALL have ports: host_req in 1, host_we in 1, host_addr in 18, host_aux in 1, host_di in 8; the host/loader request.
REQ-007 SHALL have ports: host_ack out 1 (one-cycle completion pulse), host_do out 8 (read data), host_busy out 1.
REQ-008 SHALL have ports: ram_addr out 18, ram_we out 1, ram_di out 8, ram_aux out 1, ram_do in 16 (lo byte MAIN, hi byte AUX).
REQ-009 SHALL have port: abort_cnt  out  CNT_W  saturating count of aborted host accesses.

Function
REQ-010 SHALL implement the FSM states IDLE, SETUP, ACCESS and DONE.
REQ-011 IDLE: if host_req=1 and cpu_slot=0, SHALL latch host_we/addr/aux/di and go to SETUP; otherwise SHALL stay in IDLE.
REQ-012 SETUP: SHALL drive the latched address/aux with ram_we=0; cpu_slot=1 SHALL abort to IDLE; otherwise SHALL go to ACCESS.
REQ-013 ACCESS: SHALL drive ram_we = latched_we & ~cpu_slot & ~reset.
REQ-014 ACCESS: cpu_slot=1 SHALL abort to IDLE with no write committed.
REQ-015 ACCESS: otherwise SHALL go to DONE; on a read, SHALL load host_do with ram_do[15:8] if latched aux=1, else ram_do[7:0].
REQ-016 ACCESS: on a write, host_do SHALL be unchanged.
REQ-017 DONE: host_ack=1 for exactly this cycle, then IDLE; read data SHALL be valid on host_do when host_ack=1.
REQ-018 Handshake: the host SHALL hold host_req and its fields stable until host_ack; fields are latched in IDLE only.
REQ-019 Handshake: host_req still high in the IDLE cycle after DONE SHALL start a new transaction (back-to-back allowed; min 4 cycles per access).
REQ-020 Abort: the request SHALL remain pending and be retried from IDLE automatically.
REQ-021 Abort: abort_cnt SHALL increment by 1 per abort and saturate at 2^CNT_W-1 (no wrap).
REQ-022 Mux: when cpu_slot=1, ram_addr/ram_di/ram_aux/ram_we SHALL equal the core_* inputs combinationally in every state (core always wins, zero latency).
REQ-023 Mux: when cpu_slot=0 in SETUP/ACCESS, ram_* SHALL carry the latched host fields.
REQ-024 Mux: when cpu_slot=0 in IDLE/DONE, ram_addr/ram_di/ram_aux SHALL follow core_* with ram_we=0.
REQ-025 host_busy SHALL be 1 whenever the state is not IDLE.
REQ-026 Simultaneous events: host_req=1 and cpu_slot=1 in IDLE SHALL not start a transaction (no latch, no abort count).
REQ-027 At most one RAM write SHALL occur per completed host write; an aborted write SHALL produce no RAM write.

Reset
REQ-028 On reset=1 at a clock edge: state=IDLE, host_ack=0, host_do=8'h00, abort_cnt=0, latched fields=0.
REQ-029 Reset in SETUP or ACCESS SHALL abandon the transaction with no RAM write and no host_ack; ram_we from the host path SHALL be 0 in any cycle where reset=1.
REQ-030 The core path (cpu_slot=1) SHALL pass through unaffected by reset.

Verification
REQ-031 Read, no contention: ram_do=16'hA55A; host read, aux=0, addr 18'h003F4, cpu_slot=0 -> host_ack on cycle 4 after host_req, host_do=8'h5A, ram_we never 1.
REQ-032 Aux write: host_we=1, aux=1, addr 18'h00400, di 8'hC3 -> exactly one cycle ram_we=1 (ACCESS) with ram_aux=1, ram_di=8'hC3; host_ack next cycle; host_do unchanged.
REQ-033 Abort in ACCESS: cpu_slot=1 during host write ACCESS -> ram_* equals core_* that cycle, no host write, abort_cnt=1, retry completes with exactly one write.
REQ-034 Saturation: CNT_W=2, force 5 aborts -> abort_cnt reads 3 and stays 3.
REQ-035 Reset mid-op: reset=1 in the ACCESS cycle of a write -> ram_we=0, no host_ack, next state IDLE, host_do=8'h00, abort_cnt=0.
REQ-036 Core priority: cpu_slot=1, core_we=1, core_addr 18'h01000 while host_req=1 in IDLE -> ram_we=1 at 18'h01000 that cycle, host not started, host_busy=0.
